gigerx_pkt_fifo: RTL and testbench
==================================

GIGERX_PKT_FIFO -- requirements
Module: gigerx_pkt_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, storage words; power of two.
REQ-003 SHALL have parameter PTR, default 8, log2(DEPTH).
REQ-004 SHALL have parameter AFULL_TH, default 240, almost-full threshold in words.
REQ-005 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-006 SHALL have port reset_, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port wrreq, input, 1 bit, write request.
REQ-008 SHALL have port data, input, WIDTH bits, write data.
REQ-009 SHALL have port wreop, input, 1 bit, marks the last word of a frame.
REQ-010 SHALL have port wrerr, input, 1 bit, sampled with wreop; 1 means discard the frame.
REQ-011 SHALL have port full, output, 1 bit, storage full (uncommitted words included).
REQ-012 SHALL have port afull, output, 1 bit, high when (wr_ptr - rd_ptr) >= AFULL_TH.
REQ-013 SHALL have port rdreq, input, 1 bit, read request.
REQ-014 SHALL have port q, output, WIDTH bits, registered read data.
REQ-015 SHALL have port rdeop, output, 1 bit, stored eop flag of q.
REQ-016 SHALL have port empty, output, 1 bit, no committed words available.
REQ-017 SHALL have port usedw, output, PTR+1 bits, committed unread words.
REQ-018 SHALL have port drop_cnt, output, 16 bits, count of dropped frames.

Function
REQ-019 SHALL store DEPTH words of {wreop, data}; pointers wr_ptr, cmt_ptr and rd_ptr are PTR+1 bits wide and wrap modulo 2^(PTR+1).
REQ-020 SHALL run a write FSM with states IDLE (no partial frame), WRITE (partial frame) and DROP (discarding the rest of a frame).
REQ-021 SHALL accept a write when wrreq=1, full=0 and state is not DROP; wr_ptr increments; a word without wreop moves the FSM to WRITE.
REQ-022 SHALL, on an accepted word with wreop=1 and wrerr=0, set cmt_ptr to the new wr_ptr and go to IDLE; the frame becomes readable the next cycle.
REQ-023 SHALL, on an accepted word with wreop=1 and wrerr=1, rewind wr_ptr to cmt_ptr, increment drop_cnt and go to IDLE.
REQ-024 SHALL, on wrreq=1 while full=1 (IDLE or WRITE), rewind wr_ptr to cmt_ptr and increment drop_cnt; go to IDLE if wreop=1, else to DROP.
REQ-025 SHALL, in DROP, ignore all data and return to IDLE on the first cycle with wrreq=1 and wreop=1, with no further drop_cnt increment.
REQ-026 SHALL compute full = ((wr_ptr - rd_ptr) == DEPTH), empty = (rd_ptr == cmt_ptr) and usedw = cmt_ptr - rd_ptr, all from registered pointers.
REQ-027 SHALL, on rdreq=1 with empty=0, load q/rdeop from mem[rd_ptr] at the clock edge (1-cycle latency) and increment rd_ptr.
REQ-028 SHALL ignore rdreq while empty=1; rd_ptr, q and rdeop hold.
REQ-029 SHALL permit a read and a write or commit in the same cycle; space freed by a read becomes visible to full on the next cycle.
REQ-030 SHALL saturate drop_cnt at 16'hFFFF.

Reset
REQ-031 SHALL, while reset_=0, asynchronously clear all pointers, force state to IDLE and set q=0, rdeop=0, drop_cnt=0, hence full=0, afull=0, empty=1, usedw=0; memory contents are not reset.
REQ-032 SHALL discard any partial frame when reset is asserted mid-frame.

Configuration
REQ-033 SHALL implement drop counting only when GIGERX_PKT_FIFO_STATS_EN is defined; when it is undefined, drop_cnt is tied to 0 with no counter logic, and the dropping behaviour itself is unchanged.

Verification
REQ-034 SHALL cover: write a 4-word frame (eop on word 4, wrerr=0), then 4 reads -> empty falls one cycle after the eop write, usedw=4, q returns the words in order, rdeop=1 on word 4 only.
REQ-035 SHALL cover: 3-word frame ending wreop=1/wrerr=1 -> empty stays 1, usedw=0, drop_cnt=1, wr_ptr back to 0.
REQ-036 SHALL cover: DEPTH=256, a 300-word frame -> full=1 after 256 words; the 257th wrreq causes a drop, FSM goes to DROP, drop_cnt=1; after eop, FSM is IDLE, usedw=0 and a following 2-word frame commits.
REQ-037 SHALL cover: rdreq pulses while empty=1 -> q unchanged, usedw=0, no pointer movement.
REQ-038 SHALL cover: reset_ pulsed low mid-frame after 5 words -> all outputs take their reset values immediately; the next frame commits normally.
REQ-039 SHALL cover: simultaneous rdreq and a committing eop write with usedw=1 -> next cycle usedw equals the new frame length.

Source files
------------

// File: rtl/gigerx_pkt_fifo.sv
// gigerx_pkt_fifo: frame-aware receive FIFO. Words become readable only
// once their frame ends with a good eop; errored or overflowing frames
// are rewound and discarded. Optional drop counter: GIGERX_PKT_FIFO_STATS_EN.
// Ports: clk, reset_ (async, active-low);
//   write side wrreq/data/wreop/wrerr, status full/afull;
//   read side rdreq, registered q/rdeop, status empty/usedw;
//   drop_cnt (frames discarded, saturating; 0 without STATS_EN).
module gigerx_pkt_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int PTR      = 8,
  parameter int AFULL_TH = 240
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             wreop,
  input  logic             wrerr,
  output logic             full,
  output logic             afull,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdeop,
  output logic             empty,
  output logic [PTR:0]     usedw,
  output logic [15:0]      drop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  localparam logic [PTR:0] DEPTH_P = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_P = (PTR+1)'(AFULL_TH);

  logic [WIDTH:0] mem [DEPTH];

  logic [PTR:0] wr_ptr;
  logic [PTR:0] cmt_ptr;
  logic [PTR:0] rd_ptr;
  logic [PTR:0] wr_ptr_n;
  logic [PTR:0] cmt_ptr_n;
  logic [PTR:0] fill;
  logic [1:0]   state;
  logic [1:0]   state_n;
  logic         accept;
  logic         overflow;
  logic         rd_en;

  // fill counts uncommitted words too, so a partial frame can fill the RAM
  assign fill  = wr_ptr - rd_ptr;
  assign full  = (fill == DEPTH_P);
  assign afull = (fill >= AFULL_P);
  assign empty = (rd_ptr == cmt_ptr);
  assign usedw = cmt_ptr - rd_ptr;

  assign accept   = wrreq && !full && (state != DROP);
  assign overflow = wrreq && full && (state != DROP);
  assign rd_en    = rdreq && !empty;

  always_comb begin
    wr_ptr_n  = wr_ptr;
    cmt_ptr_n = cmt_ptr;
    state_n   = state;
    unique case (1'b1)
      accept && !wreop: begin
        wr_ptr_n = wr_ptr + 1'b1;
        state_n  = WRITE;
      end
      accept && wreop && !wrerr: begin
        wr_ptr_n  = wr_ptr + 1'b1;
        cmt_ptr_n = wr_ptr + 1'b1;
        state_n   = IDLE;
      end
      accept && wreop && wrerr: begin
        wr_ptr_n = cmt_ptr;
        state_n  = IDLE;
      end
      // no room: drop the frame and swallow the rest of it
      overflow: begin
        wr_ptr_n = cmt_ptr;
        state_n  = wreop ? IDLE : DROP;
      end
      (state == DROP) && wrreq && wreop: begin
        state_n = IDLE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[PTR-1:0]] <= {wreop, data};
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      state   <= IDLE;
      q       <= '0;
      rdeop   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      cmt_ptr <= cmt_ptr_n;
      state   <= state_n;
      if (rd_en) begin
        {rdeop, q} <= mem[rd_ptr[PTR-1:0]];
        rd_ptr     <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef GIGERX_PKT_FIFO_STATS_EN
  logic        drop_ev;
  logic [15:0] cnt;

  assign drop_ev = overflow || (accept && wreop && wrerr);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (drop_ev && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign drop_cnt = cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gigerx_pkt_fifo.sv
// tb_gigerx_pkt_fifo: directed vector table, corner sequences and
// randomized traffic against a queue-based frame model.
module tb_gigerx_pkt_fifo;

`ifdef GIGERX_PKT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int DEPTH = 256;
  localparam int AFTH  = 240;

  logic       clk = 1'b0;
  logic       reset_;
  logic       wrreq;
  logic [7:0] data;
  logic       wreop;
  logic       wrerr;
  logic       full;
  logic       afull;
  logic       rdreq;
  logic [7:0] q;
  logic       rdeop;
  logic       empty;
  logic [8:0] usedw;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  gigerx_pkt_fifo dut (
    .clk      (clk),
    .reset_   (reset_),
    .wrreq    (wrreq),
    .data     (data),
    .wreop    (wreop),
    .wrerr    (wrerr),
    .full     (full),
    .afull    (afull),
    .rdreq    (rdreq),
    .q        (q),
    .rdeop    (rdeop),
    .empty    (empty),
    .usedw    (usedw),
    .drop_cnt (drop_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       eop;
    logic [7:0] d;
  } word_t;

  word_t      cq[$];
  word_t      pq[$];
  bit         m_drop;
  int         m_dcnt;
  logic [7:0] m_q;
  logic       m_eop;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic int xd(int n);
    return STATS ? n : 0;
  endfunction

  function automatic void bump();
    if (m_dcnt < 65535) m_dcnt++;
  endfunction

  task automatic do_reset();
    reset_ = 1'b0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    wreop  = 1'b0;
    wrerr  = 1'b0;
    data   = '0;
    cq.delete();
    pq.delete();
    m_drop = 1'b0;
    m_dcnt = 0;
    m_q    = '0;
    m_eop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic step(input logic w, input logic [7:0] d,
                      input logic e, input logic er, input logic r);
    bit    fullm;
    word_t x;
    wrreq = w;
    data  = d;
    wreop = e;
    wrerr = er;
    rdreq = r;
    fullm = (cq.size() + pq.size()) == DEPTH;
    if (r && cq.size() > 0) begin
      x     = cq.pop_front();
      m_q   = x.d;
      m_eop = x.eop;
    end
    if (m_drop) begin
      if (w && e) m_drop = 1'b0;
    end else if (w) begin
      if (fullm) begin
        pq.delete();
        bump();
        m_drop = !e;
      end else begin
        x.eop = e;
        x.d   = d;
        pq.push_back(x);
        if (e) begin
          if (er) begin
            pq.delete();
            bump();
          end else begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    int tot;
    tot = cq.size() + pq.size();
    check("m_q", q, m_q);
    check("m_rdeop", rdeop, m_eop);
    check("m_empty", empty, cq.size() == 0);
    check("m_usedw", usedw, cq.size());
    check("m_full", full, tot == DEPTH);
    check("m_afull", afull, tot >= AFTH);
    check("m_drop_cnt", drop_cnt, xd(m_dcnt));
  endtask

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
    logic       er;
    logic       r;
    logic       x_empty;
    int         x_used;
    logic [7:0] x_q;
    logic       x_eop;
    int         x_drop;
  } vec_t;

  vec_t tv[16];

  initial begin
    tv[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 0};
    tv[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 0};
    tv[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 0};
    tv[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 4, 8'h00, 1'b0, 0};
    tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3, 8'h11, 1'b0, 0};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'h22, 1'b0, 0};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h33, 1'b0, 0};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h44, 1'b1, 0};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h44, 1'b1, 0};
    tv[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h44, 1'b1, 0};
    tv[10] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'h44, 1'b1, 1};
    tv[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h44, 1'b1, 1};
    tv[12] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h44, 1'b1, 1};
    tv[13] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 2, 8'h77, 1'b1, 1};
    tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h88, 1'b0, 1};
    tv[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h99, 1'b1, 1};

    do_reset();
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_empty", empty, 1);
    check("rst_usedw", usedw, 0);
    check("rst_q", q, 0);
    check("rst_rdeop", rdeop, 0);
    check("rst_drop", drop_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      step(tv[i].w, tv[i].d, tv[i].e, tv[i].er, tv[i].r);
      check($sformatf("tv%0d_empty", i), empty, tv[i].x_empty);
      check($sformatf("tv%0d_usedw", i), usedw, tv[i].x_used);
      check($sformatf("tv%0d_q", i), q, tv[i].x_q);
      check($sformatf("tv%0d_rdeop", i), rdeop, tv[i].x_eop);
      check($sformatf("tv%0d_drop", i), drop_cnt, xd(tv[i].x_drop));
    end

    // errored 3-word frame leaves nothing behind
    do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
    check("err_empty", empty, 1);
    check("err_usedw", usedw, 0);
    check("err_drop", drop_cnt, xd(1));
    check("err_wr_ptr", dut.wr_ptr, 0);
    chk_model();

    // oversize frame: fills, drops, swallows remainder
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'(i), i == 299, 1'b0, 1'b0);
      if (i == 238) check("afull_239", afull, 0);
      if (i == 239) check("afull_240", afull, 1);
      if (i == 255) check("full_256", full, 1);
      if (i == 256) begin
        check("full_after_drop", full, 0);
        check("drop_on_full", drop_cnt, xd(1));
      end
      chk_model();
    end
    check("ovf_usedw", usedw, 0);
    check("ovf_empty", empty, 1);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
    check("ovf_next_usedw", usedw, 2);
    check("ovf_drop_hold", drop_cnt, xd(1));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_rd0", q, 8'hC1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_rd1", q, 8'hC2);
    check("ovf_rd1_eop", rdeop, 1);
    chk_model();

    // reset asserted mid-frame
    do_reset();
    step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("pre_rst_q", q, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    chk_model();
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    reset_ = 1'b0;
    #1;
    check("arst_q", q, 0);
    check("arst_rdeop", rdeop, 0);
    check("arst_empty", empty, 1);
    check("arst_usedw", usedw, 0);
    check("arst_full", full, 0);
    check("arst_afull", afull, 0);
    check("arst_drop", drop_cnt, 0);
    do_reset();
    step(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD3, 1'b1, 1'b0, 1'b0);
    check("post_rst_usedw", usedw, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check($sformatf("post_rst_q%0d", i), q, 8'hD1 + 8'(i));
      chk_model();
    end

    // randomized traffic: alternating fill-heavy and drain-heavy phases
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        int wp;
        int rp;
        wp = ph[0] ? 40 : 90;
        rp = ph[0] ? 70 : 15;
        step($urandom_range(99) < wp, 8'($urandom),
             $urandom_range(5) == 0, $urandom_range(7) == 0,
             $urandom_range(99) < rp);
        chk_model();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
